// File: rtl/instruction_prefetch_queue_if.sv
// AXI-Lite read channel between prefetch queue and instruction memory.
// master: drives AR and rready; slave: drives arready and R.
interface instruction_prefetch_queue_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Decoupled fetch front end: sequential AXI-Lite reads into a {pc,insn} FIFO.
// Ports: clk, rst (async low), redirect_*, bus (AR/R master), out_* to decode, stall_in.
module instruction_prefetch_queue #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  instruction_prefetch_queue_if.master bus,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  input  logic        stall_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_araddr;
  logic          r_arvalid;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [AW-1:0] r_tag_wptr;
  logic [AW-1:0] r_tag_rptr;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic          r_stale;

  logic [63:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];
  logic [63:0]   r_tag_mem [DEPTH];

  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hold;
  logic          w_credit;
  logic          w_raise;
  logic          w_stale_nxt;
  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_occ_nxt;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [63:0]   w_base_pc;
  logic [63:0]   w_tag;

  assign w_ar_hs = r_arvalid & bus.arready;
  assign w_r_hs  = bus.rvalid & bus.rready;
  assign w_empty = (r_wptr == r_rptr);
  assign w_occ   = r_wptr - r_rptr;
  assign w_tag   = r_tag_mem[r_tag_rptr];

  // Stale words are those counted in r_drop; redirect cycle pushes nothing.
  assign w_push = w_r_hs & (r_drop == '0) & ~redirect_valid;
  assign w_pop  = out_valid & ~stall_in;

  assign w_out_nxt = r_out + CW'(w_ar_hs) - CW'(w_r_hs);
  assign w_occ_nxt = redirect_valid ? '0
                   : w_occ + PW'(w_push) - PW'(w_pop);

  // Credits judged on next-cycle state so a registered AR is always safe.
  assign w_credit =
    (32'(w_occ_nxt) + 32'(w_out_nxt) < DEPTH) &&
    (32'(w_out_nxt) < MAX_OUTSTANDING);

  assign w_hold  = r_arvalid & ~bus.arready;
  assign w_raise = ~w_hold & w_credit;

  assign w_base_pc = redirect_valid ? (redirect_pc & ~64'h3)
                                    : r_fetch_pc;

  // A held AR issued before a redirect is stale; it joins drop on accept.
  always_comb begin
    w_drop_nxt  = r_drop;
    w_stale_nxt = r_stale;
    if (redirect_valid) begin
      w_drop_nxt  = w_out_nxt;
      w_stale_nxt = w_hold;
    end else begin
      if (w_r_hs && (r_drop != '0))
        w_drop_nxt = w_drop_nxt - CW'(1);
      if (w_ar_hs && r_stale)
        w_drop_nxt = w_drop_nxt + CW'(1);
      if (w_ar_hs)
        w_stale_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_araddr   <= RESET_PC;
      r_arvalid  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_stale    <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_drop  <= w_drop_nxt;
      r_stale <= w_stale_nxt;

      if (w_raise) begin
        r_arvalid  <= 1'b1;
        r_araddr   <= w_base_pc;
        r_fetch_pc <= w_base_pc + 64'd4;
      end else begin
        if (!w_hold)
          r_arvalid <= 1'b0;
        r_fetch_pc <= w_base_pc;
      end

      if (w_ar_hs)
        r_tag_wptr <= r_tag_wptr + AW'(1);
      if (w_r_hs)
        r_tag_rptr <= r_tag_rptr + AW'(1);

      if (redirect_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + PW'(1);
        if (w_pop)
          r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ar_hs)
      r_tag_mem[r_tag_wptr] <= r_araddr;
    if (w_push) begin
      r_pc_mem[r_wptr[AW-1:0]]  <= w_tag;
      r_ins_mem[r_wptr[AW-1:0]] <= bus.rdata;
    end
  end

  assign bus.arvalid = r_arvalid;
  assign bus.araddr  = r_araddr;
  assign bus.rready  = 1'b1;

  assign out_valid = ~w_empty & ~redirect_valid;
  assign out_pc    = w_empty ? '0
                   : r_pc_mem[r_rptr[AW-1:0]];
  assign out_instruction = w_empty ? '0
                         : r_ins_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: memory model plus pc/data scoreboard.
// Every popped head is checked against the expected sequential stream.
module tb_instruction_prefetch_queue;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        stall_in;

  instruction_prefetch_queue_if bus_if ();

  instruction_prefetch_queue #(
    .RESET_PC(RST_PC),
    .DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus_if),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .stall_in(stall_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int miss;
  int ar_pct;
  int r_pct;
  int pops;
  logic cur_redir;
  logic [63:0] cur_redir_pc;
  logic cur_stall;
  logic popped;
  logic [63:0] last_pc;
  logic [63:0] gen_pc;
  logic [63:0] mem_q[$];
  logic [95:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hC3A5_0F1E;
  endfunction

  task automatic step();
    logic [95:0] e;
    @(negedge clk);
    if (mem_q.size() > 0 && $urandom_range(99) < r_pct) begin
      bus_if.rvalid = 1'b1;
      bus_if.rdata  = mem_word(mem_q[0]);
    end else begin
      bus_if.rvalid = 1'b0;
      bus_if.rdata  = '0;
    end
    bus_if.arready = ($urandom_range(99) < ar_pct);
    redirect_valid = cur_redir;
    redirect_pc    = cur_redir_pc;
    stall_in       = cur_stall;
    #1;
    popped = 1'b0;
    if (redirect_valid) begin
      vec++;
      if (out_valid !== 1'b0) begin
        miss++;
        $display("FAIL redirect_gate: out_valid=%b want 0", out_valid);
      end
      sb.delete();
      gen_pc = redirect_pc & ~64'h3;
    end else if (out_valid && !stall_in) begin
      while (sb.size() < 4) begin
        sb.push_back({gen_pc, mem_word(gen_pc)});
        gen_pc = gen_pc + 64'd4;
      end
      e = sb.pop_front();
      vec++;
      if (out_pc !== e[95:32] || out_instruction !== e[31:0]) begin
        miss++;
        $display("FAIL stream: got pc=%h ins=%h want pc=%h ins=%h",
                 out_pc, out_instruction, e[95:32], e[31:0]);
      end
      popped  = 1'b1;
      last_pc = out_pc;
      pops++;
    end
    if (bus_if.rvalid && bus_if.rready)
      void'(mem_q.pop_front());
    if (bus_if.arvalid && bus_if.arready)
      mem_q.push_back(bus_if.araddr);
  endtask

  task automatic clear_model();
    mem_q.delete();
    sb.delete();
    gen_pc = RST_PC;
    bus_if.rvalid  = 1'b0;
    bus_if.rdata   = '0;
    bus_if.arready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_in       = 1'b0;
    cur_redir      = 1'b0;
    cur_redir_pc   = '0;
    cur_stall      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_model();
    #12;
    vec++;
    if (bus_if.arvalid !== 1'b0 || bus_if.araddr !== RST_PC) begin
      miss++;
      $display("FAIL reset_ar: arvalid=%b araddr=%h want 0 %h",
               bus_if.arvalid, bus_if.araddr, RST_PC);
    end
    vec++;
    if (bus_if.rready !== 1'b1) begin
      miss++;
      $display("FAIL reset_rready: got %b want 1", bus_if.rready);
    end
    vec++;
    if (out_valid !== 1'b0 || out_pc !== '0 || out_instruction !== '0) begin
      miss++;
      $display("FAIL reset_out: v=%b pc=%h ins=%h want 0 0 0",
               out_valid, out_pc, out_instruction);
    end
  endtask

  task automatic test_stream();
    int first;
    int ar_low;
    int cnt;
    do_reset();
    ar_pct = 100;
    r_pct  = 100;
    first  = 0;
    ar_low = 0;
    cnt    = 0;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (bus_if.arvalid !== 1'b1) ar_low++;
      if (popped) begin
        cnt++;
        if (first == 0) first = s;
      end
    end
    vec++;
    if (first != 3) begin
      miss++;
      $display("FAIL first_out: step %0d want 3", first);
    end
    vec++;
    if (cnt != 10) begin
      miss++;
      $display("FAIL throughput: pops %0d want 10", cnt);
    end
    vec++;
    if (ar_low != 0) begin
      miss++;
      $display("FAIL ar_steady: arvalid low %0d cycles want 0", ar_low);
    end
  endtask

  task automatic test_stall();
    int head_bad;
    int cnt;
    do_reset();
    cur_stall = 1'b1;
    head_bad  = 0;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (s >= 3 && (out_valid !== 1'b1 || out_pc !== 64'h0))
        head_bad++;
    end
    vec++;
    if (bus_if.arvalid !== 1'b0) begin
      miss++;
      $display("FAIL full_ar: arvalid=%b want 0", bus_if.arvalid);
    end
    vec++;
    if (head_bad != 0) begin
      miss++;
      $display("FAIL stall_head: %0d bad cycles want 0", head_bad);
    end
    cur_stall = 1'b0;
    cnt = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (popped) cnt++;
    end
    vec++;
    if (cnt != 8) begin
      miss++;
      $display("FAIL stall_release: pops %0d want 8", cnt);
    end
  endtask

  task automatic test_redirect();
    int k;
    repeat (4) step();
    cur_redir    = 1'b1;
    cur_redir_pc = 64'h100;
    step();
    cur_redir = 1'b0;
    step();
    vec++;
    if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== 64'h100) begin
      miss++;
      $display("FAIL redir_ar: arvalid=%b araddr=%h want 1 100",
               bus_if.arvalid, bus_if.araddr);
    end
    k = 0;
    for (int s = 1; s <= 10 && k == 0; s++) begin
      step();
      if (popped) k = s;
    end
    vec++;
    if (k != 2 || last_pc !== 64'h100) begin
      miss++;
      $display("FAIL redir_latency: step %0d pc=%h want 2 100", k, last_pc);
    end
  endtask

  task automatic test_ar_hold();
    logic [63:0] held;
    int bad;
    int k;
    repeat (3) step();
    ar_pct = 0;
    step();
    held = bus_if.araddr;
    vec++;
    if (bus_if.arvalid !== 1'b1) begin
      miss++;
      $display("FAIL hold_pre: arvalid=%b want 1", bus_if.arvalid);
    end
    repeat (2) step();
    cur_redir    = 1'b1;
    cur_redir_pc = 64'h203;
    step();
    cur_redir = 1'b0;
    bad = 0;
    if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== held) bad++;
    for (int s = 0; s < 3; s++) begin
      step();
      if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== held) bad++;
    end
    vec++;
    if (bad != 0) begin
      miss++;
      $display("FAIL hold_stable: %0d bad cycles want 0", bad);
    end
    ar_pct = 100;
    step();
    step();
    vec++;
    if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== 64'h200) begin
      miss++;
      $display("FAIL hold_next_ar: arvalid=%b araddr=%h want 1 200",
               bus_if.arvalid, bus_if.araddr);
    end
    k = 0;
    for (int s = 1; s <= 20 && k == 0; s++) begin
      step();
      if (popped) k = s;
    end
    vec++;
    if (k == 0 || last_pc !== 64'h200) begin
      miss++;
      $display("FAIL hold_first_out: step %0d pc=%h want pc 200", k, last_pc);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    ar_pct = 100;
    r_pct  = 100;
    repeat (6) step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (bus_if.arvalid !== 1'b0 || bus_if.araddr !== RST_PC ||
        out_valid !== 1'b0 || out_pc !== '0 || out_instruction !== '0) begin
      miss++;
      $display("FAIL async_reset: arv=%b ara=%h v=%b pc=%h ins=%h want 0",
               bus_if.arvalid, bus_if.araddr, out_valid, out_pc,
               out_instruction);
    end
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = 0;
    for (int s = 1; s <= 20 && k == 0; s++) begin
      step();
      if (popped) k = s;
    end
    vec++;
    if (k != 3 || last_pc !== RST_PC) begin
      miss++;
      $display("FAIL restart: step %0d pc=%h want 3 %h", k, last_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    int base;
    base   = pops;
    ar_pct = 70;
    r_pct  = 70;
    for (int i = 0; i < 10000; i++) begin
      cur_stall = ($urandom_range(99) < 30);
      cur_redir = 1'b0;
      if (i == 100) begin
        cur_redir    = 1'b1;
        cur_redir_pc = 64'hFFFF_FFFF_FFFF_FFF6;
      end else if (i == 5000) begin
        cur_redir    = 1'b1;
        cur_redir_pc = 64'h300;
      end else if (i == 5001) begin
        cur_redir    = 1'b1;
        cur_redir_pc = 64'h404;
      end else if ($urandom_range(199) == 0) begin
        cur_redir    = 1'b1;
        cur_redir_pc = {$urandom, $urandom};
      end
      step();
    end
    cur_redir = 1'b0;
    cur_stall = 1'b0;
    vec++;
    if (pops - base < 1000) begin
      miss++;
      $display("FAIL random_progress: pops %0d want >= 1000", pops - base);
    end
  endtask

  initial begin
    vec    = 0;
    miss   = 0;
    pops   = 0;
    ar_pct = 100;
    r_pct  = 100;
    last_pc = '0;
    popped  = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ar_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
